// File: rtl/tinyqv_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : tinyqv_pkg
//  Purpose  : Instruction-length encoding and length predecode shared by the
//             fetch aligner and the decoder.
//  Revision : 1.0  initial release
// ============================================================================
package tinyqv_pkg;

   // Instruction length in halfwords, as seen on instr_len[2:1] of the decoder
   localparam logic [1:0] LEN_16 = 2'b01;
   localparam logic [1:0] LEN_32 = 2'b10;

   // RISC-V length predecode: low two bits 2'b11 mark a 32-bit instruction
   function automatic logic is_32bit(input logic [15:0] hw);
      return (hw[1:0] == 2'b11);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tinyqv_fetch_align.sv
`default_nettype none
// ============================================================================
//  Module   : tinyqv_fetch_align
//  Purpose  : Halfword circular instruction buffer between the fetch path and
//             the decoder. Accepts 16/32-bit fetch beats and presents an
//             aligned 32-bit window, its length and its PC.
//  Revision : 1.0  initial release
// ============================================================================
module tinyqv_fetch_align
   import tinyqv_pkg::*;
#(
   parameter int DEPTH_HW = 4,
   parameter int IN_HW    = 1,
   parameter int ADDR_W   = 24
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [16*IN_HW-1:0]             in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            flush,
   input  logic [ADDR_W-1:0]               flush_pc,
   output logic [31:0]                     out_instr,
   output logic [1:0]                      out_len,
   output logic [ADDR_W-1:0]               out_pc,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(DEPTH_HW+1)-1:0]   level
);

   localparam int PTR_W = $clog2(DEPTH_HW);
   localparam int LVL_W = $clog2(DEPTH_HW+1);

   logic [15:0]       mem_q [DEPTH_HW];
   logic [15:0]       mem_d [DEPTH_HW];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              skip_q, skip_d;

   logic [15:0]       head_hw;
   logic [15:0]       next_hw;
   logic              head_is_32;
   logic              push;
   logic              pop;
   logic [LVL_W-1:0]  push_n;
   logic [LVL_W-1:0]  pop_n;

   // The redirect target is always halfword aligned; its byte bit is dropped
   logic unused_flush_lsb;
   assign unused_flush_lsb = flush_pc[0];

   // Output window decode straight from registered state; absent halves read as zero
   always_comb begin
      head_hw    = (count_q >= LVL_W'(1)) ? mem_q[rd_ptr_q] : 16'h0000;
      next_hw    = (count_q >= LVL_W'(2)) ? mem_q[rd_ptr_q + PTR_W'(1)] : 16'h0000;
      head_is_32 = is_32bit(head_hw);
      out_valid  = head_is_32 ? (count_q >= LVL_W'(2)) : (count_q >= LVL_W'(1));
      out_len    = head_is_32 ? LEN_32 : LEN_16;
      out_instr  = {next_hw, head_hw};
      in_ready   = (LVL_W'(DEPTH_HW) - count_q) >= LVL_W'(IN_HW);
      out_pc     = pc_q;
      level      = count_q;
   end

   // Queue bookkeeping: push, consume and redirect resolved into next state
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pc_d     = pc_q;
      skip_d   = skip_q;

      // A redirect cancels whatever else happens this cycle
      push   = in_valid && in_ready && !flush;
      pop    = out_valid && out_ready && !flush;
      pop_n  = pop ? (head_is_32 ? LVL_W'(2) : LVL_W'(1)) : '0;
      push_n = '0;

      if (push) begin
         if (skip_q) begin
            // First beat after a misaligned redirect: lower halfword precedes the target
            mem_d[wr_ptr_q] = in_data[16*IN_HW-1 -: 16];
            push_n          = LVL_W'(1);
            skip_d          = 1'b0;
         end else begin
            for (int i = 0; i < IN_HW; i++) begin
               mem_d[wr_ptr_q + PTR_W'(i)] = in_data[16*i +: 16];
            end
            push_n = LVL_W'(IN_HW);
         end
      end

      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      count_d  = count_q + push_n - pop_n;
      pc_d     = pc_q + ADDR_W'({pop_n, 1'b0});

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         pc_d     = {flush_pc[ADDR_W-1:1], 1'b0};
         skip_d   = (IN_HW == 2) && flush_pc[1];
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH_HW; i++) begin
            mem_q[i] <= 16'h0000;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         pc_q     <= '0;
         skip_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         pc_q     <= pc_d;
         skip_q   <= skip_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/tinyqv_fetch_align.md
# tinyqv_fetch_align

Parametrised halfword instruction buffer sitting between the tinyQV fetch path and `tinyqv_decoder`. Accepts 16- or 32-bit fetch beats, stores them as halfwords in a circular queue, and presents a 32-bit aligned instruction window plus its length (2 or 4 bytes) and PC to the decoder. Handles mixed compressed/uncompressed streams, instructions straddling fetch beats, and redirects (flush with new PC, including halfword-misaligned targets).

## Interface
- `DEPTH_HW`, 4: queue depth in halfwords; power of two, ≥4.
- `IN_HW`, 1: halfwords per input beat; 1 or 2.
- `ADDR_W`, 24: PC width in bits.

- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_data`  in  16*IN_HW  fetch beat; halfword 0 in bits [15:0] is lowest address.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  buffer can accept a full beat this cycle.
- `flush`  in  1  discard contents, redirect to `flush_pc`.
- `flush_pc`  in  ADDR_W  redirect target; bit 0 ignored.
- `out_instr`  out  32  instruction window; [15:0] = head halfword, [31:16] = next halfword (zero if absent).
- `out_len`  out  2  instruction length in bytes / 2, i.e. `instr_len[2:1]` of the decoder: 2'b01 compressed, 2'b10 full.
- `out_pc`  out  ADDR_W  byte address of `out_instr[15:0]`; bit 0 always 0.
- `out_valid`  out  1  complete instruction present.
- `out_ready`  in  1  decoder consumes the instruction.
- `level`  out  $clog2(DEPTH_HW+1)  halfwords held (debug/perf).

## Operation
- Storage: `DEPTH_HW` x 16 register array, read pointer, write pointer, count. Pointers wrap modulo `DEPTH_HW`.
- Length predecode on head halfword: `[1:0] == 2'b11` → 32-bit, else 16-bit.
- `out_valid` = (count ≥ 1 and head is 16-bit) or (count ≥ 2 and head is 32-bit). A 32-bit instruction with only its low half present holds `out_valid` low.
- Consume (`out_valid & out_ready`): read pointer += 1 or 2, count −= same, `out_pc` += 2 or 4 (wraps modulo 2^ADDR_W).
- `in_ready` = (DEPTH_HW − count) ≥ IN_HW, computed from registered count only; a same-cycle pop does not raise it.
- Push (`in_valid & in_ready`): write IN_HW halfwords at write pointer; count += IN_HW minus skip (below).
- Push and consume in the same cycle both take effect; count updates by the net amount.
- Flush: count, pointers → 0; `out_pc` ← `{flush_pc[ADDR_W-1:1],1'b0}`. A push in the flush cycle is dropped. A consume in the flush cycle is ignored.
- Misaligned redirect (IN_HW=2 only): if `flush_pc[1]` = 1, a `skip` flag is set; the first accepted beat after flush writes only its upper halfword (count += 1) and clears `skip`. For IN_HW=1, `flush_pc[1]` affects only `out_pc`.
- Unused window half (count = 1) drives zeros.

## Timing
- Reset: count 0, pointers 0, `skip` 0, `out_pc` 0, `out_valid` 0, `in_ready` 1, `level` 0, `out_instr` 0.
- Push → `out_valid` visible next cycle (registered storage, combinational output decode). No output-side register stage.
- Flush → `out_valid` low next cycle; new-PC beat accepted the cycle after flush.
- Throughput: one instruction per cycle while the buffer holds enough halfwords; IN_HW=2 sustains one 32-bit instruction per cycle.
- Reset asserted mid-stream clears everything asynchronously; no residual instruction after release.

## Structure
- `tinyqv_pkg`: instruction-length encoding constants (`LEN_16 = 2'b01`, `LEN_32 = 2'b10`) and the `is_32bit(halfword)` predecode function, shared with the decoder.
- Single module; no sub-module needed (queue is inline, too small to split).

## Test plan
- IN_HW=1, push 0x0001, 0x4501 (two compressed) → two outputs, `out_len`=01, PCs 0x000000, 0x000002.
- IN_HW=2, push 0x00A00513 then 0x0001_4581 → 32-bit 0x00A00513 @0, then 0x4581 @4, then 0x0001 @6.
- Straddle: IN_HW=1, push 0x0001, 0x0513, hold, then push 0x00A0 → `out_valid` low while 0x0513 alone at head; asserts with 0x00A00513, len 10, after the third push.
- Flush to 0x000102 with IN_HW=2, then push 0x4581_FFFF → only 0x4581 enqueued, `out_pc`=0x000102, `level`=1.
- Fill DEPTH_HW=4 with `out_ready`=0 → `in_ready` low at level 4; one 16-bit consume with `in_valid` high → no push that cycle, push accepted next cycle.
- Reset asserted with level 3 → all outputs at reset values immediately; flush concurrent with push → push dropped, level 0.
